// File: rtl/reg_bus_initiator.sv
// Register-bus initiator.
// Queues read/write commands in a small FIFO. Issues them one at a time on the
// reg_op/reg_addr/reg_wdata bus, waits out the responder's read latency, and
// returns one in-order response per command.
module reg_bus_initiator #(
  parameter int DWIDTH     = 8,
  parameter int AWIDTH     = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int RD_LATENCY = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [AWIDTH-1:0] req_addr,
  input  logic [DWIDTH-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_write,
  output logic [AWIDTH-1:0] rsp_addr,
  output logic [DWIDTH-1:0] rsp_rdata,
  output logic [1:0]        reg_op,
  output logic [AWIDTH-1:0] reg_addr,
  output logic [DWIDTH-1:0] reg_wdata,
  input  logic [DWIDTH-1:0] reg_rdata,
  output logic              busy,
  output logic [15:0]       rd_count,
  output logic [15:0]       wr_count
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int EW = 1 + AWIDTH + DWIDTH;
  localparam int CW = $clog2(RD_LATENCY + 1);

  localparam logic [1:0] OP_NOP = 2'b00;
  localparam logic [1:0] OP_RD  = 2'b01;
  localparam logic [1:0] OP_WR  = 2'b10;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  // FIFO entry layout: {write, addr, wdata}
  logic [EW-1:0] fifo_mem [FIFO_DEPTH];
  logic [PW:0]   wr_ptr;
  logic [PW:0]   rd_ptr;
  logic          fifo_empty;
  logic          fifo_full;
  logic          push;
  logic          pop;
  logic [EW-1:0] head;

  logic [1:0]    state;
  logic [CW-1:0] wait_cnt;
  logic          cur_write;

  // Pointers carry one extra wrap bit to tell full from empty.
  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[PW] != rd_ptr[PW]) &&
                      (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);

  // Readiness depends only on the registered fill level, so a pop in the
  // same cycle never makes room for a push into a full FIFO.
  assign req_ready = !fifo_full && !rst;
  assign push      = req_valid && req_ready;
  assign head      = fifo_mem[rd_ptr[PW-1:0]];

  // Pop from IDLE, or straight out of RESP on the response handshake so that
  // back-to-back commands skip the IDLE cycle.
  assign pop = !fifo_empty &&
               ((state == S_IDLE) ||
                ((state == S_RESP) && rsp_valid && rsp_ready));

  assign busy = !fifo_empty || (state != S_IDLE);

  // Command storage; contents need no reset because the pointers gate them.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr[PW-1:0]] <= {req_write, req_addr, req_wdata};
    end
  end

  // FIFO pointer bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Transaction FSM: drives the bus for one cycle, then builds the response.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      reg_op    <= OP_NOP;
      reg_addr  <= '0;
      reg_wdata <= '0;
      rsp_valid <= 1'b0;
      rsp_write <= 1'b0;
      rsp_addr  <= '0;
      rsp_rdata <= '0;
      rd_count  <= '0;
      wr_count  <= '0;
      wait_cnt  <= '0;
      cur_write <= 1'b0;
    end else begin
      // An op occupies the bus for exactly one cycle; address/data hold.
      reg_op <= OP_NOP;
      if (rsp_valid && rsp_ready) rsp_valid <= 1'b0;

      if (pop) begin
        cur_write <= head[EW-1];
        reg_op    <= head[EW-1] ? OP_WR : OP_RD;
        reg_addr  <= head[EW-2:DWIDTH];
        reg_wdata <= head[DWIDTH-1:0];
        state     <= S_ISSUE;
      end else if ((state == S_RESP) && rsp_valid && rsp_ready) begin
        state <= S_IDLE;
      end

      case (state)
        S_ISSUE: begin
          if (cur_write) begin
            rsp_valid <= 1'b1;
            rsp_write <= 1'b1;
            rsp_addr  <= reg_addr;
            rsp_rdata <= '0;
            wr_count  <= wr_count + 16'd1;
            state     <= S_RESP;
          end else begin
            wait_cnt <= CW'(RD_LATENCY);
            state    <= S_WAIT;
          end
        end
        S_WAIT: begin
          // Count of 1 marks the cycle the responder's data is valid.
          if (wait_cnt == CW'(1)) begin
            rsp_valid <= 1'b1;
            rsp_write <= 1'b0;
            rsp_addr  <= reg_addr;
            rsp_rdata <= reg_rdata;
            rd_count  <= rd_count + 16'd1;
            state     <= S_RESP;
          end else begin
            wait_cnt <= wait_cnt - CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_reg_bus_initiator.sv
// Bench for reg_bus_initiator: directed steps plus random traffic checked
// against an in-order response model, with responder models at latency 1 and 3.
`timescale 1ns/1ps
module tb_reg_bus_initiator;

  typedef struct packed {
    logic       w;
    logic [7:0] a;
    logic [7:0] d;
  } rsp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // latency-1 instance
  logic        req_valid, req_ready, req_write;
  logic [7:0]  req_addr, req_wdata;
  logic        rsp_valid, rsp_ready, rsp_write;
  logic [7:0]  rsp_addr, rsp_rdata;
  logic [1:0]  reg_op;
  logic [7:0]  reg_addr, reg_wdata, reg_rdata;
  logic        busy;
  logic [15:0] rd_count, wr_count;

  // latency-3 instance
  logic        b_req_valid, b_req_ready, b_req_write;
  logic [7:0]  b_req_addr, b_req_wdata;
  logic        b_rsp_valid, b_rsp_ready, b_rsp_write;
  logic [7:0]  b_rsp_addr, b_rsp_rdata;
  logic [1:0]  b_reg_op;
  logic [7:0]  b_reg_addr, b_reg_wdata, b_reg_rdata;
  logic        b_busy;
  logic [15:0] b_rd_count, b_wr_count;

  reg_bus_initiator #(.DWIDTH(8), .AWIDTH(8), .FIFO_DEPTH(4), .RD_LATENCY(1)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
    .rsp_addr(rsp_addr), .rsp_rdata(rsp_rdata),
    .reg_op(reg_op), .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_rdata(reg_rdata),
    .busy(busy), .rd_count(rd_count), .wr_count(wr_count)
  );

  reg_bus_initiator #(.DWIDTH(8), .AWIDTH(8), .FIFO_DEPTH(4), .RD_LATENCY(3)) dut3 (
    .clk(clk), .rst(rst),
    .req_valid(b_req_valid), .req_ready(b_req_ready), .req_write(b_req_write),
    .req_addr(b_req_addr), .req_wdata(b_req_wdata),
    .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready), .rsp_write(b_rsp_write),
    .rsp_addr(b_rsp_addr), .rsp_rdata(b_rsp_rdata),
    .reg_op(b_reg_op), .reg_addr(b_reg_addr), .reg_wdata(b_reg_wdata), .reg_rdata(b_reg_rdata),
    .busy(b_busy), .rd_count(b_rd_count), .wr_count(b_wr_count)
  );

  // Responders: read data is valid only in the exact latency cycle, random
  // junk otherwise, so a too-early or too-late capture shows up.
  logic [7:0] mem1 [256];
  logic       pv1;
  logic [7:0] pd1, junk1;
  always @(posedge clk) begin
    junk1 <= 8'($urandom);
    if (rst) for (int i = 0; i < 256; i++) mem1[i] <= 8'h00;
    else if (reg_op == 2'b10) mem1[reg_addr] <= reg_wdata;
    pv1 <= (reg_op == 2'b01);
    pd1 <= mem1[reg_addr];
  end
  assign reg_rdata = pv1 ? pd1 : junk1;

  logic [7:0] mem3 [256];
  logic [2:0] pv3;
  logic [7:0] pd3 [3];
  logic [7:0] junk3;
  always @(posedge clk) begin
    junk3 <= 8'($urandom);
    if (rst) for (int i = 0; i < 256; i++) mem3[i] <= 8'h00;
    else if (b_reg_op == 2'b10) mem3[b_reg_addr] <= b_reg_wdata;
    pv3    <= {pv3[1:0], b_reg_op == 2'b01};
    pd3[0] <= mem3[b_reg_addr];
    pd3[1] <= pd3[0];
    pd3[2] <= pd3[1];
  end
  assign b_reg_rdata = pv3[2] ? pd3[2] : junk3;

  // Reference model state
  rsp_t       exp_q [$];
  rsp_t       b_got [$];
  logic [7:0] mmem [256];
  logic [1:0] ops [$];
  int   n_vec = 0, n_err = 0;
  int   m_wr = 0, m_rd = 0;
  bit   rec_en = 1'b0;
  bit   prev_hold = 1'b0;
  rsp_t prev_rsp;
  int   cyc = 0, b_rd_cyc = 0, b_lat = -1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  // Sample one cycle just before its closing edge, update the model, move on.
  task automatic advance();
    rsp_t cur, e;
    #1;
    cyc++;
    if (rec_en) ops.push_back(reg_op);
    chk("op_legal", {31'd0, reg_op != 2'b11}, 32'd1);
    cur = {rsp_write, rsp_addr, rsp_rdata};
    if (rst) begin
      exp_q.delete();
      m_wr = 0;
      m_rd = 0;
      prev_hold = 1'b0;
      for (int i = 0; i < 256; i++) mmem[i] = 8'h00;
    end else begin
      if (prev_hold) begin
        chk("hold_valid", {31'd0, rsp_valid}, 32'd1);
        chk("hold_rsp", cur, prev_rsp);
      end
      if (req_valid && req_ready) begin
        if (req_write) begin
          mmem[req_addr] = req_wdata;
          exp_q.push_back({1'b1, req_addr, 8'h00});
        end else begin
          exp_q.push_back({1'b0, req_addr, mmem[req_addr]});
        end
      end
      if (rsp_valid && rsp_ready) begin
        $display("rsp write=%0d addr=%02h rdata=%02h", rsp_write, rsp_addr, rsp_rdata);
        chk("rsp_expected", {31'd0, exp_q.size() != 0}, 32'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("rsp", cur, e);
          if (e.w) m_wr++;
          else m_rd++;
        end
      end
      prev_hold = rsp_valid && !rsp_ready;
      prev_rsp  = cur;
    end
    if (b_reg_op == 2'b01) b_rd_cyc = cyc;
    if (b_rsp_valid && b_rsp_ready) begin
      $display("b_rsp write=%0d addr=%02h rdata=%02h", b_rsp_write, b_rsp_addr, b_rsp_rdata);
      b_got.push_back({b_rsp_write, b_rsp_addr, b_rsp_rdata});
      if (!b_rsp_write) b_lat = cyc - b_rd_cyc;
    end
    @(negedge clk);
  endtask

  task automatic push(input logic w, input logic [7:0] a, input logic [7:0] d);
    req_valid = 1'b1;
    req_write = w;
    req_addr  = a;
    req_wdata = d;
    advance();
  endtask

  initial begin
    int idx;
    logic [1:0] exp_ops [8];
    exp_ops = '{2'b10, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b00, 2'b01};

    rst = 1'b1;
    req_valid = 1'b0; req_write = 1'b0; req_addr = 8'h00; req_wdata = 8'h00; rsp_ready = 1'b0;
    b_req_valid = 1'b0; b_req_write = 1'b0; b_req_addr = 8'h00; b_req_wdata = 8'h00; b_rsp_ready = 1'b1;
    for (int i = 0; i < 256; i++) mmem[i] = 8'h00;
    @(negedge clk);

    // Reset
    repeat (3) begin
      chk("rst_req_ready", {31'd0, req_ready}, 32'd0);
      advance();
    end
    chk("rst_reg_op", reg_op, 32'd0);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_rd_count", rd_count, 32'd0);
    chk("rst_wr_count", wr_count, 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'd0);
    rst = 1'b0;
    #1 chk("post_rst_ready", {31'd0, req_ready}, 32'd1);

    // Write / read-back
    rsp_ready = 1'b1;
    rec_en = 1'b1;
    push(1'b1, 8'h00, 8'hA5);
    push(1'b1, 8'h01, 8'h5A);
    push(1'b0, 8'h00, 8'h00);
    push(1'b0, 8'h01, 8'h00);
    req_valid = 1'b0;
    repeat (14) advance();
    rec_en = 1'b0;
    idx = -1;
    for (int i = 0; i < ops.size(); i++) if (idx < 0 && ops[i] != 2'b00) idx = i;
    for (int i = 0; i < 8; i++)
      chk("op_seq", (idx >= 0 && idx + i < ops.size()) ? ops[idx + i] : 2'b11, exp_ops[i]);
    chk("t1_drained", exp_q.size(), 32'd0);
    chk("t1_wr_count", wr_count, 32'd2);
    chk("t1_rd_count", rd_count, 32'd2);
    chk("t1_busy", {31'd0, busy}, 32'd0);

    // Response backpressure
    rsp_ready = 1'b0;
    push(1'b0, 8'h01, 8'h00);
    push(1'b1, 8'h00, 8'h11);
    req_valid = 1'b0;
    for (int i = 0; i < 20 && rsp_valid !== 1'b1; i++) advance();
    chk("bp_arrive", {31'd0, rsp_valid}, 32'd1);
    for (int i = 0; i < 6; i++) begin
      chk("bp_valid", {31'd0, rsp_valid}, 32'd1);
      chk("bp_rdata", rsp_rdata, 32'h5A);
      chk("bp_op", reg_op, 32'd0);
      advance();
    end
    rsp_ready = 1'b1;
    advance();
    chk("bp_wr_issue", reg_op, 32'd2);
    chk("bp_wr_addr", reg_addr, 32'h00);
    chk("bp_wr_data", reg_wdata, 32'h11);
    chk("bp_rsp_drop", {31'd0, rsp_valid}, 32'd0);
    repeat (4) advance();
    chk("bp_drained", exp_q.size(), 32'd0);

    // FIFO full: one in flight plus four queued
    rsp_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      req_valid = 1'b1;
      req_write = 1'($urandom_range(0, 1));
      req_addr  = 8'($urandom_range(0, 3));
      req_wdata = 8'($urandom);
      #1 chk("full_ready", {31'd0, req_ready}, (i < 5) ? 32'd1 : 32'd0);
      advance();
    end
    req_valid = 1'b0;
    chk("full_accepted", exp_q.size(), 32'd5);
    for (int i = 0; i < 100 && (exp_q.size() != 0 || busy); i++) begin
      rsp_ready = 1'($urandom_range(0, 1));
      advance();
    end
    chk("full_drained", exp_q.size(), 32'd0);
    chk("full_busy", {31'd0, busy}, 32'd0);

    // Random traffic
    for (int i = 0; i < 300; i++) begin
      req_valid = ($urandom_range(0, 1) == 1);
      req_write = 1'($urandom_range(0, 1));
      req_addr  = 8'($urandom_range(0, 7));
      req_wdata = 8'($urandom);
      rsp_ready = ($urandom_range(0, 3) != 0);
      advance();
    end
    req_valid = 1'b0;
    for (int i = 0; i < 100 && (exp_q.size() != 0 || busy); i++) begin
      rsp_ready = 1'($urandom_range(0, 1));
      advance();
    end
    chk("rand_drained", exp_q.size(), 32'd0);
    chk("rand_wr_count", wr_count, m_wr);
    chk("rand_rd_count", rd_count, m_rd);

    // Reset during a read with two requests queued
    rsp_ready = 1'b1;
    push(1'b0, 8'h02, 8'h00);
    push(1'b0, 8'h03, 8'h00);
    push(1'b0, 8'h04, 8'h00);
    req_valid = 1'b0;
    chk("mid_busy", {31'd0, busy}, 32'd1);
    chk("mid_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    rst = 1'b1;
    advance();
    advance();
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      chk("mid_no_rsp", {31'd0, rsp_valid}, 32'd0);
      chk("mid_op_nop", reg_op, 32'd0);
      advance();
    end
    chk("mid_busy_after", {31'd0, busy}, 32'd0);
    chk("mid_rd_count", rd_count, 32'd0);
    chk("mid_req_ready", {31'd0, req_ready}, 32'd1);

    // Latency-3 build: write 0x3C then read it back
    b_got.delete();
    b_req_valid = 1'b1; b_req_write = 1'b1; b_req_addr = 8'h00; b_req_wdata = 8'h3C;
    #1 chk("b_ready", {31'd0, b_req_ready}, 32'd1);
    advance();
    b_req_write = 1'b0; b_req_wdata = 8'h00;
    advance();
    b_req_valid = 1'b0;
    for (int i = 0; i < 40 && b_got.size() < 2; i++) advance();
    chk("b_rsp_count", b_got.size(), 32'd2);
    if (b_got.size() >= 2) begin
      chk("b_wr_rsp", b_got[0], {1'b1, 8'h00, 8'h00});
      chk("b_rd_rsp", b_got[1], {1'b0, 8'h00, 8'h3C});
      chk("b_rd_latency", b_lat, 32'd4);
    end
    chk("b_rd_count", b_rd_count, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/reg_bus_initiator.md
Name: reg_bus_initiator

Overview:
Master end of the two-register control bus. It accepts read/write requests on a valid/ready command port and queues them in a small FIFO. It drives reg_op/reg_addr/reg_wdata toward a register responder, one transaction at a time, and captures reg_rdata after the responder's registered read latency. Each request returns exactly one in-order response on a valid/ready response port. It sits between a test/CPU-side command source and any block with the register-bus responder interface.

Parameters:
DWIDTH, 8, data width of reg_wdata/reg_rdata/req_wdata/rsp_rdata
AWIDTH, 8, address width
FIFO_DEPTH, 4, request FIFO entries (power of 2, >=2)
RD_LATENCY, 1, cycles from the cycle reg_op=RD is on the bus to the cycle reg_rdata is valid (>=1)

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
req_valid  in  1  request present
req_ready  out  1  request accepted when valid&&ready
req_write  in  1  1=write, 0=read
req_addr  in  AWIDTH  request address
req_wdata  in  DWIDTH  write data (ignored for reads)
rsp_valid  out  1  response present
rsp_ready  in  1  response consumed when valid&&ready
rsp_write  out  1  echo of request type
rsp_addr  out  AWIDTH  echo of request address
rsp_rdata  out  DWIDTH  read data; 0 for write responses
reg_op  out  2  bus op: NOP=2'b00, RD=2'b01, WR=2'b10, 2'b11 never driven
reg_addr  out  AWIDTH  bus address
reg_wdata  out  DWIDTH  bus write data
reg_rdata  in  DWIDTH  bus read data from responder
busy  out  1  FIFO non-empty or FSM not IDLE
rd_count  out  16  completed reads, wraps 0xFFFF->0
wr_count  out  16  completed writes, wraps 0xFFFF->0

Behaviour:
- Reset values: reg_op=NOP; reg_addr, reg_wdata, rsp_* and counters = 0; FIFO empty; FSM=IDLE; busy=0. req_ready=0 while rst is high.
- req_ready = !fifo_full && !rst, combinational. A push on a full FIFO is never accepted, even if a pop occurs in the same cycle. Push and pop in the same non-full cycle are both honoured.
- All reg_* and rsp_* outputs are registered.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE: if the FIFO is non-empty, pop the head, load reg_op/addr/wdata from it, and go to ISSUE. Otherwise stay, with reg_op=NOP.
- ISSUE: the op is on the bus for exactly one cycle; reg_op returns to NOP next cycle.
  - Write: load rsp (rdata=0), assert rsp_valid, increment wr_count, go to RESP.
  - Read: load the wait counter with RD_LATENCY and go to WAIT.
- WAIT: decrement the counter each cycle. When it reaches 1, capture reg_rdata into rsp_rdata, assert rsp_valid, increment rd_count, and go to RESP.
- With RD_LATENCY=1, the capture occurs in the cycle immediately after ISSUE.
- RESP: hold all rsp_* stable until rsp_ready.
  - On handshake, if the FIFO is non-empty, pop and go straight to ISSUE (back-to-back issue). Otherwise go to IDLE.
  - rsp_valid deasserts on handshake unless a new response is loaded.
- reg_addr/reg_wdata hold their last values while reg_op=NOP.
- Only one transaction is outstanding; responses are always in request order.
- Write throughput: one per 2 cycles with rsp_ready held high. Read throughput: one per 2+RD_LATENCY cycles.
- Reset mid-transaction: the in-flight op and queued requests are discarded, no response is produced, and reg_op is NOP the cycle after rst.
- Counter wrap is silent; no saturation.

Test Plan:
- Reset: hold rst 3 cycles -> reg_op=NOP, rsp_valid=0, req_ready=0 during rst, 1 the cycle after; busy=0, counters=0.
- Write/read-back with a responder model and rsp_ready=1:
  - Stimulus: WR 0x00<-0xA5, WR 0x01<-0x5A, RD 0x00, RD 0x01.
  - Bus: reg_op sequence WR,NOP,WR,NOP,RD,NOP,NOP,RD.
  - Responses: rdata 0,0,0xA5,0x5A in order; wr_count=2, rd_count=2.
- Response backpressure: RD 0x01 (holds 0x5A), then WR 0x00<-0x11, with rsp_ready=0 for 6 cycles -> rsp_valid/rsp_rdata=0x5A stable for 6 cycles, reg_op stays NOP, write not issued until the handshake.
- FIFO full: rsp_ready=0, push 6 requests back-to-back -> 5 accepted (1 in flight + 4 queued), req_ready low from the 6th cycle. Releasing rsp_ready drains all 5 responses in order.
- RD_LATENCY=3 build: responder model with 3-cycle read latency, RD 0x00 after writing 0x3C -> rsp_rdata=0x3C. reg_rdata must not be sampled earlier.
- Reset mid-read: assert rst during WAIT with 2 requests queued -> no rsp_valid ever asserted for them, FIFO empty, busy=0 after reset.
